// File: rtl/axis_reg_pipeline.sv
// AXI-Stream register pipeline: PL_DEPTH chained skid-buffer stages, every
// output (including upstream tready) driven from a flop. PL_DEPTH=0 is a wire.
module axis_reg_pipeline #(
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10,
    parameter int PL_DEPTH    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     axis_s_tvalid,
    output logic                     axis_s_tready,
    input  logic [TDATA_WIDTH-1:0]   axis_s_tdata,
    input  logic [TDATA_WIDTH/8-1:0] axis_s_tkeep,
    input  logic                     axis_s_tlast,
    input  logic [TUSER_WIDTH-1:0]   axis_s_tuser_vendor,
    output logic                     axis_m_tvalid,
    input  logic                     axis_m_tready,
    output logic [TDATA_WIDTH-1:0]   axis_m_tdata,
    output logic [TDATA_WIDTH/8-1:0] axis_m_tkeep,
    output logic                     axis_m_tlast,
    output logic [TUSER_WIDTH-1:0]   axis_m_tuser_vendor
);
    localparam int KW = TDATA_WIDTH / 8;
    localparam int PW = TDATA_WIDTH + KW + 1 + TUSER_WIDTH;

    // Index gi is the sink side of stage gi; index gi+1 is its source side.
    logic [PL_DEPTH:0] w_vld;
    logic [PL_DEPTH:0] w_rdy;
    logic [PW-1:0]     w_dat [PL_DEPTH+1];

    assign w_vld[0]         = axis_s_tvalid;
    assign w_dat[0]         = {axis_s_tdata, axis_s_tkeep, axis_s_tlast, axis_s_tuser_vendor};
    assign axis_s_tready    = w_rdy[0];
    assign w_rdy[PL_DEPTH]  = axis_m_tready;
    assign axis_m_tvalid    = w_vld[PL_DEPTH];
    assign {axis_m_tdata, axis_m_tkeep, axis_m_tlast, axis_m_tuser_vendor} = w_dat[PL_DEPTH];

    for (genvar gi = 0; gi < PL_DEPTH; gi++) begin : g_stage
        logic          r_main_valid;
        logic          r_skid_valid;
        logic          r_s_tready;
        logic [PW-1:0] r_main_data;
        logic [PW-1:0] r_skid_data;
        logic          w_accept;
        logic          w_main_open;
        logic          w_skid_load;
        logic          w_main_valid_next;
        logic          w_skid_valid_next;

        assign w_accept    = w_vld[gi] && r_s_tready;
        assign w_main_open = !r_main_valid || w_rdy[gi+1];
        // Skid takes the incoming beat only if main stays occupied after this edge.
        assign w_skid_load = w_accept && (!w_main_open || r_skid_valid);

        always_comb begin
            w_main_valid_next = r_main_valid;
            w_skid_valid_next = r_skid_valid;
            if (w_main_open) begin
                w_main_valid_next = r_skid_valid || w_accept;
                w_skid_valid_next = r_skid_valid && w_accept;
            end else if (w_accept) begin
                w_skid_valid_next = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
                r_s_tready   <= 1'b0;
            end else begin
                r_main_valid <= w_main_valid_next;
                r_skid_valid <= w_skid_valid_next;
                r_s_tready   <= !w_skid_valid_next;
            end
        end

        // Payload carries no reset; it is qualified by the valid bits above.
        always_ff @(posedge clk) begin
            if (w_main_open) begin
                r_main_data <= r_skid_valid ? r_skid_data : w_dat[gi];
            end
            if (w_skid_load) begin
                r_skid_data <= w_dat[gi];
            end
        end

        assign w_rdy[gi]    = r_s_tready;
        assign w_vld[gi+1]  = r_main_valid;
        assign w_dat[gi+1]  = r_main_data;
    end

endmodule

// File: tb/tb_axis_reg_pipeline.sv
// Directed and scoreboarded bench for axis_reg_pipeline at PL_DEPTH 0..3,
// one instance per depth sharing clock and reset.
module tb_axis_reg_pipeline;
    localparam int DW = 64;
    localparam int UW = 10;
    localparam int KW = DW / 8;
    localparam int PW = DW + KW + 1 + UW;
    localparam int ND = 4;
    localparam int NRAND = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          s_valid [ND];
    logic          s_ready [ND];
    logic [DW-1:0] s_data  [ND];
    logic [KW-1:0] s_keep  [ND];
    logic          s_last  [ND];
    logic [UW-1:0] s_user  [ND];
    logic          m_valid [ND];
    logic          m_ready [ND];
    logic [DW-1:0] m_data  [ND];
    logic [KW-1:0] m_keep  [ND];
    logic          m_last  [ND];
    logic [UW-1:0] m_user  [ND];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        axis_reg_pipeline #(
            .TDATA_WIDTH(DW),
            .TUSER_WIDTH(UW),
            .PL_DEPTH   (gi)
        ) u_dut (
            .clk                 (clk),
            .rst_n               (rst_n),
            .axis_s_tvalid       (s_valid[gi]),
            .axis_s_tready       (s_ready[gi]),
            .axis_s_tdata        (s_data[gi]),
            .axis_s_tkeep        (s_keep[gi]),
            .axis_s_tlast        (s_last[gi]),
            .axis_s_tuser_vendor (s_user[gi]),
            .axis_m_tvalid       (m_valid[gi]),
            .axis_m_tready       (m_ready[gi]),
            .axis_m_tdata        (m_data[gi]),
            .axis_m_tkeep        (m_keep[gi]),
            .axis_m_tlast        (m_last[gi]),
            .axis_m_tuser_vendor (m_user[gi])
        );
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] m_pl(input int d);
        return {m_data[d], m_keep[d], m_last[d], m_user[d]};
    endfunction

    function automatic logic [PW-1:0] s_pl(input int d);
        return {s_data[d], s_keep[d], s_last[d], s_user[d]};
    endfunction

    function automatic logic [PW-1:0] pl_of(input int c);
        logic [DW-1:0] dd;
        dd = {32'(c), ~32'(c)};
        return {dd, 8'(c * 5), c[0], 10'(c * 7)};
    endfunction

    function automatic logic [PW-1:0] rand_pl();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[PW-1:0];
    endfunction

    task automatic drive_s(input int d, input logic v, input logic [PW-1:0] p);
        s_valid[d] = v;
        {s_data[d], s_keep[d], s_last[d], s_user[d]} = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int d, input int n);
        logic [PW-1:0] q[$];
        logic [PW-1:0] held;
        logic [PW-1:0] exp;
        logic          in_fire;
        logic          out_fire;
        logic          stall;
        int sent = 0;
        int rcvd = 0;
        int cyc  = 0;
        drive_s(d, 1'b0, '0);
        m_ready[d] = 1'b0;
        while (rcvd < n && cyc < 60000) begin
            if (!s_valid[d] && sent < n && $urandom_range(1, 0) == 1) begin
                drive_s(d, 1'b1, rand_pl());
            end
            m_ready[d] = ($urandom_range(1, 0) == 1);
            in_fire  = s_valid[d] && s_ready[d];
            out_fire = m_valid[d] && m_ready[d];
            stall    = m_valid[d] && !m_ready[d];
            held     = m_pl(d);
            if (in_fire) q.push_back(s_pl(d));
            if (out_fire) begin
                if (q.size() == 0) begin
                    check_val($sformatf("rand_d%0d_extra_beat", d), 128'(1), 128'(0));
                end else begin
                    exp = q.pop_front();
                    check_val($sformatf("rand_d%0d_beat%0d", d, rcvd), 128'(held), 128'(exp));
                end
                rcvd++;
            end
            tick();
            if (in_fire) begin
                sent++;
                s_valid[d] = 1'b0;
            end
            if (stall) begin
                check_val($sformatf("rand_d%0d_stall_valid", d), 128'(m_valid[d]), 128'(1));
                check_val($sformatf("rand_d%0d_stall_data", d), 128'(m_pl(d)), 128'(held));
            end
            cyc++;
        end
        check_val($sformatf("rand_d%0d_count", d), 128'(rcvd), 128'(n));
        drive_s(d, 1'b0, '0);
        m_ready[d] = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] p;
        logic          fire;
        int            idx;
        int            cnt;

        for (int d = 0; d < ND; d++) begin
            drive_s(d, 1'b0, '0);
            m_ready[d] = 1'b0;
        end

        // Reset state
        #1;
        for (int d = 1; d < ND; d++) begin
            check_val($sformatf("reset_m_valid_d%0d", d), 128'(m_valid[d]), 128'(0));
            check_val($sformatf("reset_s_ready_d%0d", d), 128'(s_ready[d]), 128'(0));
        end
        #12 rst_n = 1'b1;
        tick();
        for (int d = 1; d < ND; d++) begin
            check_val($sformatf("post_reset_s_ready_d%0d", d), 128'(s_ready[d]), 128'(1));
        end

        // Single beat, depth 1
        p = {{8{8'hA5}}, 8'hFF, 1'b1, 10'h155};
        m_ready[1] = 1'b1;
        drive_s(1, 1'b1, p);
        check_val("single_s_ready", 128'(s_ready[1]), 128'(1));
        check_val("single_pre_m_valid", 128'(m_valid[1]), 128'(0));
        tick();
        drive_s(1, 1'b0, '0);
        check_val("single_m_valid", 128'(m_valid[1]), 128'(1));
        check_val("single_payload", 128'(m_pl(1)), 128'(p));
        tick();
        check_val("single_m_valid_gone", 128'(m_valid[1]), 128'(0));
        m_ready[1] = 1'b0;

        // 100-beat stream, depth 2, ready held high
        m_ready[2] = 1'b1;
        for (int c = 0; c < 102; c++) begin
            if (c < 100) begin
                drive_s(2, 1'b1, pl_of(c));
                check_val($sformatf("stream_s_ready_c%0d", c), 128'(s_ready[2]), 128'(1));
            end else begin
                drive_s(2, 1'b0, '0);
            end
            tick();
            if (c >= 1 && c <= 100) begin
                check_val($sformatf("stream_m_valid_c%0d", c), 128'(m_valid[2]), 128'(1));
                check_val($sformatf("stream_data_c%0d", c), 128'(m_pl(2)), 128'(pl_of(c - 1)));
            end else begin
                check_val($sformatf("stream_m_idle_c%0d", c), 128'(m_valid[2]), 128'(0));
            end
        end

        // Backpressure, depth 2: four beats fill both stages, then tready falls
        m_ready[2] = 1'b0;
        idx = 0;
        for (int c = 0; c < 9; c++) begin
            if (idx < 4) drive_s(2, 1'b1, pl_of(200 + idx));
            else         drive_s(2, 1'b0, '0);
            check_val($sformatf("bp_s_ready_c%0d", c), 128'(s_ready[2]), 128'(c < 4 ? 1 : 0));
            fire = s_valid[2] && s_ready[2];
            tick();
            if (fire) idx++;
            if (c >= 1) begin
                check_val($sformatf("bp_m_valid_c%0d", c), 128'(m_valid[2]), 128'(1));
                check_val($sformatf("bp_stable_c%0d", c), 128'(m_pl(2)), 128'(pl_of(200)));
            end
        end
        check_val("bp_accepted", 128'(idx), 128'(4));
        m_ready[2] = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (m_valid[2] && m_ready[2]) begin
                check_val($sformatf("bp_drain_%0d", cnt), 128'(m_pl(2)), 128'(pl_of(200 + cnt)));
                cnt++;
            end
            tick();
        end
        check_val("bp_drain_count", 128'(cnt), 128'(4));
        check_val("bp_drained_idle", 128'(m_valid[2]), 128'(0));
        m_ready[2] = 1'b0;

        // Random traffic on depths 1..3 concurrently
        fork
            run_random(1, NRAND);
            run_random(2, NRAND);
            run_random(3, NRAND);
        join

        // Asynchronous reset with beats buffered
        m_ready[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_s(2, 1'b1, pl_of(300 + c));
            tick();
        end
        drive_s(2, 1'b0, '0);
        check_val("pre_rst_m_valid", 128'(m_valid[2]), 128'(1));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int d = 1; d < ND; d++) begin
            check_val($sformatf("async_rst_m_valid_d%0d", d), 128'(m_valid[d]), 128'(0));
            check_val($sformatf("async_rst_s_ready_d%0d", d), 128'(s_ready[d]), 128'(0));
        end
        #3 rst_n = 1'b1;
        tick();
        check_val("rst_rel_s_ready", 128'(s_ready[2]), 128'(1));
        check_val("rst_rel_m_valid", 128'(m_valid[2]), 128'(0));
        m_ready[2] = 1'b1;
        drive_s(2, 1'b1, pl_of(400));
        tick();
        drive_s(2, 1'b0, '0);
        for (int c = 0; c < 10; c++) begin
            if (m_valid[2]) break;
            tick();
        end
        check_val("rst_first_valid", 128'(m_valid[2]), 128'(1));
        check_val("rst_first_payload", 128'(m_pl(2)), 128'(pl_of(400)));
        m_ready[2] = 1'b0;

        // Depth 0: combinational mirror
        for (int i = 0; i < 4; i++) begin
            drive_s(0, i[0], pl_of(500 + i));
            m_ready[0] = i[1];
            #1;
            check_val($sformatf("pass_m_valid_%0d", i), 128'(m_valid[0]), 128'(i[0]));
            check_val($sformatf("pass_payload_%0d", i), 128'(m_pl(0)), 128'(pl_of(500 + i)));
            check_val($sformatf("pass_s_ready_%0d", i), 128'(s_ready[0]), 128'(i[1]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
